chacha_block_engine: RTL and testbench

Iterative ChaCha block function engine: loads a 512-bit input state from key, IV and block counter, drives four parallel `chacha_qr` quarter-round instances through the configured number of rounds, adds the input state, and presents one 512-bit keystream block. It sits directly upstream of `chacha_qr`, sequencing column and diagonal rounds, and downstream of the cipher top level, which supplies key material and consumes keystream.

---
 rtl/chacha_pkg.sv | 58 +++++
 rtl/chacha_block_engine_if.sv | 23 ++
 rtl/chacha_qr.sv | 33 +++
 rtl/chacha_block_engine.sv | 140 ++++++++++++++
 tb/tb_chacha_block_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and quarter-round index tables for the ChaCha block engine.
package chacha_pkg;

  localparam int ROUND_CTR_W = 5;

  typedef logic [ROUND_CTR_W-1:0] round_ctr_t;
  typedef logic [3:0]             word_idx_t;
  typedef logic [15:0][31:0]      state_words_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_FINAL  = 2'd2
  } fsm_state_t;

  // "expand 32-byte k" as little-endian words
  localparam logic [31:0] SIGMA [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  // Row q lists the (a, b, c, d) working-state words fed to quarter-round q.
  localparam word_idx_t COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam word_idx_t DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Word 0 of the state sits in element 0; key words run MSB-first into x4..x11.
  function automatic state_words_t load_state(input logic [255:0] key,
                                              input logic [63:0]  ctr,
                                              input logic [63:0]  iv);
    state_words_t s;
    for (int i = 0; i < 4; i++) begin
      s[i] = SIGMA[i];
    end
    for (int i = 0; i < 8; i++) begin
      s[4+i] = key[255-32*i -: 32];
    end
    s[12] = ctr[31:0];
    s[13] = ctr[63:32];
    s[14] = iv[31:0];
    s[15] = iv[63:32];
    return s;
  endfunction

endpackage

// File: rtl/chacha_block_engine_if.sv
// Command/keystream bundle between the cipher top level (master) and the block engine (slave).
interface chacha_block_engine_if;

  logic         init;
  logic         next;
  logic [255:0] key;
  logic [63:0]  iv;
  logic [63:0]  ctr;
  logic         ready;
  logic [511:0] data_out;
  logic         data_out_valid;

  modport master (
    output init, next, key, iv, ctr,
    input  ready, data_out, data_out_valid
  );

  modport slave (
    input  init, next, key, iv, ctr,
    output ready, data_out, data_out_valid
  );

endinterface

// File: rtl/chacha_qr.sv
// Purely combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_res,
  output logic [31:0] b_res,
  output logic [31:0] c_res,
  output logic [31:0] d_res
);

  logic [31:0] a1, b1, c1, d1;
  logic [31:0] a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl32(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl32(b ^ c1, 12);

  assign a2 = a1 + b1;
  assign d2 = rotl32(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl32(b1 ^ c2, 7);

  assign a_res = a2;
  assign b_res = b2;
  assign c_res = c2;
  assign d_res = d2;

endmodule

// File: rtl/chacha_block_engine.sv
// Iterative ChaCha block function: one round per cycle on four parallel quarter-rounds,
// followed by the feed-forward addition of the input state.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  chacha_block_engine_if.slave bus
);

  localparam round_ctr_t LAST_ROUND = round_ctr_t'(ROUNDS - 1);

  fsm_state_t   state_reg, state_next;
  round_ctr_t   round_reg, round_next;
  state_words_t working_reg, working_next;
  state_words_t input_reg, input_next;
  state_words_t round_words;
  logic [511:0] data_out_reg, data_out_next;
  logic         valid_reg, valid_next;
  logic [63:0]  ctr_inc;
  logic         odd_round;

  logic [31:0] qr_in  [4][4];
  logic [31:0] qr_out [4][4];

  // Even round indices are column rounds, odd ones diagonal rounds.
  assign odd_round = round_reg[0];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_qr
      for (gj = 0; gj < 4; gj++) begin : g_word
        assign qr_in[gi][gj] = odd_round ? working_reg[DIAG_IDX[gi][gj]]
                                         : working_reg[COL_IDX[gi][gj]];
      end

      chacha_qr u_qr (
        .a     (qr_in[gi][0]),
        .b     (qr_in[gi][1]),
        .c     (qr_in[gi][2]),
        .d     (qr_in[gi][3]),
        .a_res (qr_out[gi][0]),
        .b_res (qr_out[gi][1]),
        .c_res (qr_out[gi][2]),
        .d_res (qr_out[gi][3])
      );
    end
  endgenerate

  // Each round touches every word exactly once, so the demux fully overwrites the default.
  always_comb begin
    round_words = working_reg;
    for (int q = 0; q < 4; q++) begin
      for (int k = 0; k < 4; k++) begin
        if (odd_round) begin
          round_words[DIAG_IDX[q][k]] = qr_out[q][k];
        end else begin
          round_words[COL_IDX[q][k]] = qr_out[q][k];
        end
      end
    end
  end

  assign ctr_inc = {input_reg[13], input_reg[12]} + 64'd1;

  always_comb begin
    state_next    = state_reg;
    round_next    = round_reg;
    working_next  = working_reg;
    input_next    = input_reg;
    data_out_next = data_out_reg;
    valid_next    = valid_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.init) begin
          input_next   = load_state(bus.key, bus.ctr, bus.iv);
          working_next = input_next;
          round_next   = '0;
          valid_next   = 1'b0;
          state_next   = ST_ROUNDS;
        end else if (bus.next) begin
          // Reuses stored key/IV; before any init this runs on the all-zero state.
          input_next[12] = ctr_inc[31:0];
          input_next[13] = ctr_inc[63:32];
          working_next   = input_next;
          round_next     = '0;
          valid_next     = 1'b0;
          state_next     = ST_ROUNDS;
        end
      end

      ST_ROUNDS: begin
        working_next = round_words;
        round_next   = round_reg + 1'b1;
        if (round_reg == LAST_ROUND) begin
          state_next = ST_FINAL;
        end
      end

      ST_FINAL: begin
        for (int i = 0; i < 16; i++) begin
          data_out_next[511-32*i -: 32] = working_reg[i] + input_reg[i];
        end
        valid_next = 1'b1;
        round_next = '0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      round_reg    <= '0;
      working_reg  <= '0;
      input_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      round_reg    <= round_next;
      working_reg  <= working_next;
      input_reg    <= input_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
    end
  end

  assign bus.ready          = (state_reg == ST_IDLE);
  assign bus.data_out       = data_out_reg;
  assign bus.data_out_valid = valid_reg;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Bench for chacha_block_engine: ChaCha20 and ChaCha8 instances checked against a
// double-round reference model, known vectors and hand-written timing sequences.
module tb_chacha_block_engine;

  typedef logic [31:0] words_t [16];

  typedef struct {
    bit           use8;
    logic [255:0] key;
    logic [63:0]  iv;
    logic [63:0]  ctr;
    int           n_next;
    logic [511:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  chacha_block_engine_if if20 ();
  chacha_block_engine_if if8 ();

  chacha_block_engine #(.ROUNDS(20)) dut20 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if20.slave)
  );

  chacha_block_engine #(.ROUNDS(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if8.slave)
  );

  int errors = 0;
  int checks = 0;

  vec_t vecs [8];

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic words_t make_state(input logic [255:0] key, input logic [63:0] ctr,
                                        input logic [63:0] iv);
    words_t s;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key[255-32*i -: 32];
    s[12] = ctr[31:0];
    s[13] = ctr[63:32];
    s[14] = iv[31:0];
    s[15] = iv[63:32];
    return s;
  endfunction

  // Textbook formulation: rounds/2 double rounds, each 4 column QRs then 4 diagonal QRs.
  function automatic logic [511:0] model_block(input words_t s, input int rounds);
    words_t       x;
    int           q [8][4];
    logic [511:0] o;
    q = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int g = 0; g < 8; g++) begin
        int a = q[g][0];
        int b = q[g][1];
        int c = q[g][2];
        int d = q[g][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) o[511-32*i -: 32] = x[i] + s[i];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] dout(input bit u8);
    return u8 ? if8.data_out : if20.data_out;
  endfunction

  function automatic logic dvalid(input bit u8);
    return u8 ? if8.data_out_valid : if20.data_out_valid;
  endfunction

  function automatic logic drdy(input bit u8);
    return u8 ? if8.ready : if20.ready;
  endfunction

  task automatic clear_cmds();
    if20.init = 1'b0; if20.next = 1'b0;
    if8.init  = 1'b0; if8.next  = 1'b0;
  endtask

  // Drive a command for one edge (E0); returns just after E0 with the command removed.
  task automatic start(input bit u8, input bit do_init, input logic [255:0] k,
                       input logic [63:0] c, input logic [63:0] v);
    @(negedge clk);
    if (u8) begin
      if8.init = do_init; if8.next = !do_init; if8.key = k; if8.ctr = c; if8.iv = v;
    end else begin
      if20.init = do_init; if20.next = !do_init; if20.key = k; if20.ctr = c; if20.iv = v;
    end
    @(posedge clk);
    #1;
    clear_cmds();
  endtask

  task automatic wait_valid(input bit u8, output int edges);
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (dvalid(u8)) break;
    end
  endtask

  // Start a block, confirm acceptance, wait for completion and check latency.
  task automatic run_block(input string tag, input bit u8, input bit do_init,
                           input logic [255:0] k, input logic [63:0] c, input logic [63:0] v,
                           output logic [511:0] blk);
    int edges;
    int rounds;
    rounds = u8 ? 8 : 20;
    start(u8, do_init, k, c, v);
    check({tag, "_accept_valid_low"}, 512'(dvalid(u8)), 512'(0));
    check({tag, "_accept_ready_low"}, 512'(drdy(u8)), 512'(0));
    wait_valid(u8, edges);
    check({tag, "_latency_edges"}, 512'(edges), 512'(rounds + 1));
    check({tag, "_ready_back"}, 512'(drdy(u8)), 512'(1));
    blk = dout(u8);
    $display("txn %s rounds=%0d op=%s edges=%0d word0=%h", tag, rounds,
             do_init ? "init" : "next", edges, blk[511:480]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [511:0] blk0, blk, exp;
    words_t       zst;
    int           rises;
    logic         prev_valid;

    clear_cmds();
    if20.key = '0; if20.ctr = '0; if20.iv = '0;
    if8.key  = '0; if8.ctr  = '0; if8.iv  = '0;

    for (int v = 0; v < 8; v++) begin
      vecs[v].use8 = (v % 2) == 1;
      for (int w = 0; w < 8; w++) vecs[v].key[32*w +: 32] = $urandom;
      vecs[v].iv = {$urandom, $urandom};
      if (v == 0) begin
        vecs[v].ctr = 64'hFFFF_FFFF_FFFF_FFFE; vecs[v].n_next = 2;
      end else if (v == 1) begin
        vecs[v].ctr = 64'h0000_0000_FFFF_FFFF; vecs[v].n_next = 1;
      end else begin
        vecs[v].ctr = {$urandom, $urandom}; vecs[v].n_next = int'($urandom_range(0, 2));
      end
      vecs[v].exp = model_block(make_state(vecs[v].key, vecs[v].ctr + 64'(vecs[v].n_next),
                                           vecs[v].iv), vecs[v].use8 ? 8 : 20);
    end

    blk0 = model_block(make_state('0, '0, '0), 20);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready20", 512'(if20.ready), 512'(1));
    check("rst_valid20", 512'(if20.data_out_valid), 512'(0));
    check("rst_dout20", if20.data_out, 512'(0));
    check("rst_ready8", 512'(if8.ready), 512'(1));
    check("rst_valid8", 512'(if8.data_out_valid), 512'(0));
    check("rst_dout8", if8.data_out, 512'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // next before any init: all-zero input state with counter 1, constants zero
    for (int i = 0; i < 16; i++) zst[i] = 32'd0;
    zst[12] = 32'd1;
    run_block("c8_next_first", 1'b1, 1'b0, '0, '0, '0, blk);
    check("c8_next_first_block", blk, model_block(zst, 8));

    // ChaCha8 zero vector
    run_block("c8_zero", 1'b1, 1'b1, '0, '0, '0, blk);
    check("c8_zero_word0", 512'(blk[511:480]), 512'(32'h2fef003e));
    check("c8_zero_block", blk, model_block(make_state('0, '0, '0), 8));

    // ChaCha20 zero vector, then next with counter 1
    run_block("c20_zero", 1'b0, 1'b1, '0, '0, '0, blk);
    check("c20_zero_word0", 512'(blk[511:480]), 512'(32'hade0b876));
    check("c20_zero_word1", 512'(blk[479:448]), 512'(32'h903df1a0));
    check("c20_zero_block", blk, blk0);

    run_block("c20_next1", 1'b0, 1'b0, 256'(1234), 64'(77), 64'(99), blk);
    check("c20_next1_word0", 512'(blk[511:480]), 512'(32'hbee7079f));
    check("c20_next1_block", blk, model_block(make_state('0, 64'd1, '0), 20));

    // Counter wrap
    run_block("c20_wrap_init", 1'b0, 1'b1, '0, 64'hFFFF_FFFF_FFFF_FFFF, '0, blk);
    check("c20_wrap_init_block", blk, model_block(make_state('0, 64'hFFFF_FFFF_FFFF_FFFF, '0), 20));
    run_block("c20_wrap_next", 1'b0, 1'b0, '0, '0, '0, blk);
    check("c20_wrap_next_word0", 512'(blk[511:480]), 512'(32'hade0b876));
    check("c20_wrap_next_block", blk, blk0);

    // Commands during a running block must be ignored
    start(1'b0, 1'b1, '0, '0, '0);
    check("busy_accept_valid_low", 512'(if20.data_out_valid), 512'(0));
    rises = 0;
    prev_valid = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if20.init = (k % 2 == 1) ? 1'b1 : 1'(($urandom % 2));
      if20.next = (k % 2 == 0) ? 1'b1 : 1'(($urandom % 2));
      for (int w = 0; w < 8; w++) if20.key[32*w +: 32] = $urandom;
      if20.ctr = {$urandom, $urandom};
      if20.iv  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      if (if20.data_out_valid && !prev_valid) rises++;
      prev_valid = if20.data_out_valid;
      check($sformatf("busy_ready_e%0d", k), 512'(if20.ready), 512'(k > 20 ? 1 : 0));
    end
    clear_cmds();
    repeat (4) begin
      @(posedge clk);
      #1;
      if (if20.data_out_valid && !prev_valid) rises++;
      prev_valid = if20.data_out_valid;
    end
    check("busy_valid_rises", 512'(rises), 512'(1));
    check("busy_valid_held", 512'(if20.data_out_valid), 512'(1));
    check("busy_block", if20.data_out, blk0);
    $display("txn busy_ignore rises=%0d word0=%h", rises, if20.data_out[511:480]);

    // Reset in the middle of a block
    start(1'b0, 1'b1, '0, '0, '0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 512'(if20.ready), 512'(1));
    check("midrst_valid", 512'(if20.data_out_valid), 512'(0));
    check("midrst_dout", if20.data_out, 512'(0));
    $display("txn mid_reset ready=%0b valid=%0b", if20.ready, if20.data_out_valid);
    @(negedge clk);
    reset_n = 1'b1;
    run_block("c20_after_rst", 1'b0, 1'b1, '0, '0, '0, blk);
    check("c20_after_rst_block", blk, blk0);

    // Randomized vector table
    for (int v = 0; v < 8; v++) begin
      run_block($sformatf("vec%0d_init", v), vecs[v].use8, 1'b1,
                vecs[v].key, vecs[v].ctr, vecs[v].iv, blk);
      for (int n = 0; n < vecs[v].n_next; n++) begin
        run_block($sformatf("vec%0d_next%0d", v, n), vecs[v].use8, 1'b0, '0, '0, '0, blk);
      end
      exp = vecs[v].exp;
      check($sformatf("vec%0d_block", v), blk, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
